// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: byte-wide RAM bus between the MEM-stage load/store unit and the RAM arbiter.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              memReq_out;
    logic              mem_wr_out;
    logic [ADDR_W-1:0] mem_a_out;
    logic [7:0]        mem_dout_out;
    logic              memGrant_in;
    logic [7:0]        mem_din_in;

    // load/store unit side
    modport master (
        output memReq_out,
        output mem_wr_out,
        output mem_a_out,
        output mem_dout_out,
        input  memGrant_in,
        input  mem_din_in
    );

    // RAM / arbiter side
    modport slave (
        input  memReq_out,
        input  mem_wr_out,
        input  mem_a_out,
        input  mem_dout_out,
        output memGrant_in,
        output mem_din_in
    );

endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Loads and stores are moved one byte per
// granted bus cycle, little-endian; the pipeline is stalled while an access is in flight.
// Non-memory instructions pass their rd fields straight through, combinationally.
// Optional feature macro: MEM_MISALIGN_CHECK_EN adds misalign_out and retires misaligned
// halfword/word accesses as NOPs without touching the bus.

`ifndef instIdxRange
`define instIdxRange 5:0
`endif
`ifndef regIdxRange
`define regIdxRange 4:0
`endif
`ifndef regNOP
`define regNOP 5'd0
`endif
`ifndef writeDisable
`define writeDisable 1'b0
`endif
`ifndef idNOP
`define idNOP  6'd0
`define idLB   6'd10
`define idLH   6'd11
`define idLW   6'd12
`define idLBU  6'd13
`define idLHU  6'd14
`define idSB   6'd15
`define idSH   6'd16
`define idSW   6'd17
`define idADDI 6'd20
`endif

module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [`instIdxRange] instIdx_in,
    input  logic [31:0]          memAddr_in,
    input  logic [31:0]          valStore_in,
    input  logic                 rdE_in,
    input  logic [`regIdxRange]  rdIdx_in,
    input  logic [31:0]          rdData_in,
    mem_access_unit_if.master    bus,
    output logic                 stall_out,
    output logic                 rdE_out,
    output logic [`regIdxRange]  rdIdx_out,
    output logic [31:0]          rdData_out
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                 misalign_out
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iss_q, iss_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic             pend_q, pend_d;
    logic [XLEN-1:0]  buf_q, buf_d;

    logic             is_mem;
    logic             is_load;
    logic             is_signed;
    logic [CNT_W-1:0] size_n;
    logic             misaligned;
    logic             can_issue;
    logic [XLEN-1:0]  byte_addr;
    logic [XLEN-1:0]  load_val;

    // instruction class and access size
    always_comb begin
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size_n    = '0;
        case (instIdx_in)
            `idLB:  begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; size_n = CNT_W'(1); end
            `idLBU: begin is_mem = 1'b1; is_load = 1'b1;                   size_n = CNT_W'(1); end
            `idLH:  begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; size_n = CNT_W'(2); end
            `idLHU: begin is_mem = 1'b1; is_load = 1'b1;                   size_n = CNT_W'(2); end
            `idLW:  begin is_mem = 1'b1; is_load = 1'b1;                   size_n = CNT_W'(4); end
            `idSB:  begin is_mem = 1'b1;                                   size_n = CNT_W'(1); end
            `idSH:  begin is_mem = 1'b1;                                   size_n = CNT_W'(2); end
            `idSW:  begin is_mem = 1'b1;                                   size_n = CNT_W'(4); end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // halfwords need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        misaligned = 1'b0;
        if (size_n == CNT_W'(2)) begin
            misaligned = memAddr_in[0];
        end else if (size_n == CNT_W'(4)) begin
            misaligned = |memAddr_in[1:0];
        end
    end

    // one-cycle flag for a misaligned access retired as a NOP
    assign misalign_out = ~rst_in & (state_q == S_IDLE) & is_mem & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // address of the next byte to issue; wraps modulo 2^32
    assign byte_addr = memAddr_in + XLEN'(iss_q);

    // sign/zero extension of the assembled little-endian load buffer
    always_comb begin
        case (size_n)
            CNT_W'(1): load_val = is_signed ? {{24{buf_q[7]}}, buf_q[7:0]}
                                            : {24'd0, buf_q[7:0]};
            CNT_W'(2): load_val = is_signed ? {{16{buf_q[15]}}, buf_q[15:0]}
                                            : {16'd0, buf_q[15:0]};
            default:   load_val = buf_q;
        endcase
    end

    // next state, counters, byte capture and all unit outputs
    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        pend_d  = 1'b0;
        buf_d   = buf_q;

        bus.memReq_out   = 1'b0;
        bus.mem_wr_out   = 1'b0;
        bus.mem_a_out    = '0;
        bus.mem_dout_out = '0;
        stall_out        = 1'b0;
        rdE_out          = `writeDisable;
        rdIdx_out        = `regNOP;
        rdData_out       = '0;
        can_issue        = 1'b0;

        // read data for the byte issued last cycle is on the bus now
        if (pend_q) begin
            buf_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din_in;
            cap_d = cap_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!is_mem) begin
                    rdE_out    = rdE_in;
                    rdIdx_out  = rdIdx_in;
                    rdData_out = rdData_in;
                end else if (!misaligned) begin
                    stall_out = 1'b1;
                    can_issue = 1'b1;
                end
            end
            S_ACCESS: begin
                stall_out = 1'b1;
                can_issue = 1'b1;
            end
            S_WAIT: begin
                stall_out = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                rdIdx_out  = rdIdx_in;
                rdE_out    = is_load ? rdE_in : `writeDisable;
                rdData_out = is_load ? load_val : '0;
                iss_d      = '0;
                cap_d      = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // byte issue: one per granted cycle, never repeated
        if (can_issue && (iss_q < size_n)) begin
            bus.memReq_out = 1'b1;
            if (bus.memGrant_in) begin
                bus.mem_a_out    = ADDR_W'(byte_addr);
                bus.mem_wr_out   = ~is_load;
                bus.mem_dout_out = is_load ? 8'd0 : 8'(valStore_in >> {iss_q[1:0], 3'b000});
                pend_d           = is_load;
                iss_d            = iss_q + CNT_W'(1);
                if (iss_d == size_n) begin
                    state_d = is_load ? S_WAIT : S_DONE;
                end else begin
                    state_d = S_ACCESS;
                end
            end
        end

        // outputs read 0 while reset is asserted
        if (rst_in) begin
            bus.memReq_out   = 1'b0;
            bus.mem_wr_out   = 1'b0;
            bus.mem_a_out    = '0;
            bus.mem_dout_out = '0;
            stall_out        = 1'b0;
            rdE_out          = `writeDisable;
            rdIdx_out        = `regNOP;
            rdData_out       = '0;
        end
    end

    // state, counters and load buffer registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            iss_q   <= '0;
            cap_q   <= '0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural RAM slave
// and a byte-array reference model of memory and load extension.

`ifndef instIdxRange
`define instIdxRange 5:0
`endif
`ifndef regIdxRange
`define regIdxRange 4:0
`endif
`ifndef regNOP
`define regNOP 5'd0
`endif
`ifndef writeDisable
`define writeDisable 1'b0
`endif
`ifndef idNOP
`define idNOP  6'd0
`define idLB   6'd10
`define idLH   6'd11
`define idLW   6'd12
`define idLBU  6'd13
`define idLHU  6'd14
`define idSB   6'd15
`define idSH   6'd16
`define idSW   6'd17
`define idADDI 6'd20
`endif

module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [`instIdxRange] instIdx_in;
    logic [31:0]          memAddr_in;
    logic [31:0]          valStore_in;
    logic                 rdE_in;
    logic [`regIdxRange]  rdIdx_in;
    logic [31:0]          rdData_in;
    logic                 stall_out;
    logic                 rdE_out;
    logic [`regIdxRange]  rdIdx_out;
    logic [31:0]          rdData_out;
`ifdef MEM_MISALIGN_CHECK_EN
    logic                 misalign_out;
`endif

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .instIdx_in  (instIdx_in),
        .memAddr_in  (memAddr_in),
        .valStore_in (valStore_in),
        .rdE_in      (rdE_in),
        .rdIdx_in    (rdIdx_in),
        .rdData_in   (rdData_in),
        .bus         (bus),
        .stall_out   (stall_out),
        .rdE_out     (rdE_out),
        .rdIdx_out   (rdIdx_out),
        .rdData_out  (rdData_out)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_out(misalign_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_exp_t;

    typedef struct packed {
        logic                rde;
        logic [`regIdxRange] ridx;
        logic [31:0]         rdata;
        logic                misal;
    } ret_exp_t;

    bus_exp_t    bus_q[$];
    ret_exp_t    ret_q[$];
    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        tb_valid = 1'b0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int op_size(input logic [`instIdxRange] op);
        case (op)
            `idLB, `idLBU, `idSB: return 1;
            `idLH, `idLHU, `idSH: return 2;
            `idLW, `idSW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [`instIdxRange] op);
        return (op == `idLB) || (op == `idLBU) || (op == `idLH) || (op == `idLHU) || (op == `idLW);
    endfunction

    function automatic bit op_misal(input logic [`instIdxRange] op, input logic [31:0] a);
        bit m;
        m = ((op_size(op) == 2) && a[0]) || ((op_size(op) == 4) && (a[1:0] != 2'b00));
`ifdef MEM_MISALIGN_CHECK_EN
        return m;
`else
        return m & 1'b0;
`endif
    endfunction

    // reference load result: little-endian bytes from the model memory, then extension
    function automatic logic [31:0] model_load(input logic [`instIdxRange] op, input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
        case (op)
            `idLB:   return {{24{w[7]}}, w[7:0]};
            `idLBU:  return {24'd0, w[7:0]};
            `idLH:   return {{16{w[15]}}, w[15:0]};
            `idLHU:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic grant_for(input int gmode, input int cyc);
        case (gmode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return !((cyc == 1) || (cyc == 2));
        endcase
    endfunction

    task automatic drive_idle();
        instIdx_in  = `idNOP;
        memAddr_in  = 32'd0;
        valStore_in = 32'd0;
        rdE_in      = 1'b0;
        rdIdx_in    = '0;
        rdData_in   = 32'd0;
    endtask

    // push expectations, apply the instruction, hold it until the unit stops stalling
    task automatic run_instr(input logic [`instIdxRange] op, input logic [31:0] addr,
                             input logic [31:0] sval, input logic rde,
                             input logic [`regIdxRange] ridx, input logic [31:0] rdat,
                             input int gmode, input int exp_stall, input string name);
        int       n;
        bit       ld;
        ret_exp_t r;
        bus_exp_t b;
        int       stalls;
        int       cyc;
        n  = op_size(op);
        ld = op_load(op);
        if (n == 0) begin
            r.rde = rde; r.ridx = ridx; r.rdata = rdat; r.misal = 1'b0;
        end else if (op_misal(op, addr)) begin
            r.rde = `writeDisable; r.ridx = `regNOP; r.rdata = 32'd0; r.misal = 1'b1;
        end else begin
            r.rde   = ld ? rde : 1'b0;
            r.ridx  = ridx;
            r.rdata = ld ? model_load(op, addr) : 32'd0;
            r.misal = 1'b0;
            for (int i = 0; i < n; i++) begin
                b.wr   = !ld;
                b.addr = addr + 32'(i);
                b.data = ld ? 8'h00 : sval[8*i +: 8];
                bus_q.push_back(b);
                if (!ld) ref_mem[b.addr] = b.data;
            end
        end
        ret_q.push_back(r);

        instIdx_in  = op;
        memAddr_in  = addr;
        valStore_in = sval;
        rdE_in      = rde;
        rdIdx_in    = ridx;
        rdData_in   = rdat;
        tb_valid    = 1'b1;
        stalls      = 0;
        cyc         = 0;
        forever begin
            bus.memGrant_in = grant_for(gmode, cyc);
            @(negedge clk_in);
            if (!stall_out) break;
            stalls++;
            cyc++;
            if (cyc > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s timeout: still stalled after %0d cycles, required retire", name, cyc);
                break;
            end
            @(posedge clk_in);
            #1;
        end
        if (exp_stall >= 0) check({name, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk_in);
        #1;
        tb_valid = 1'b0;
        drive_idle();
    endtask

    // RAM slave: writes land at issue, read data appears the cycle after issue
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in && bus.memReq_out && bus.memGrant_in) begin
                if (bus.mem_wr_out) begin
                    ram[32'(bus.mem_a_out)] = bus.mem_dout_out;
                end else begin
                    rd_pend = 1'b1;
                    rd_addr = 32'(bus.mem_a_out);
                end
            end
        end
    end

    initial begin
        bus.mem_din_in = 8'h00;
        forever begin
            @(posedge clk_in);
            #1;
            if (rd_pend) begin
                bus.mem_din_in = ram_rd(rd_addr);
                rd_pend = 1'b0;
            end else begin
                bus.mem_din_in = 8'($urandom);
            end
        end
    end

    // monitor: compare every bus issue and every retirement against the scoreboard
    initial begin
        bus_exp_t e;
        ret_exp_t r;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (bus.memReq_out && bus.memGrant_in) begin
                    n_cmp++;
                    if (bus_q.size() == 0) begin
                        n_err++;
                        $display("FAIL bus_extra: got wr=%b a=%h d=%h, required no issue",
                                 bus.mem_wr_out, bus.mem_a_out, bus.mem_dout_out);
                    end else begin
                        e = bus_q.pop_front();
                        if ((e.addr !== 32'(bus.mem_a_out)) || (e.wr !== bus.mem_wr_out) ||
                            (e.wr && (e.data !== bus.mem_dout_out))) begin
                            n_err++;
                            $display("FAIL bus_issue: got wr=%b a=%h d=%h required wr=%b a=%h d=%h",
                                     bus.mem_wr_out, bus.mem_a_out, bus.mem_dout_out,
                                     e.wr, e.addr, e.data);
                        end
                    end
                end
                if (tb_valid && !stall_out) begin
                    if (ret_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL retire_extra: got rdData=%h, required no retirement", rdData_out);
                    end else begin
                        r = ret_q.pop_front();
                        check("retire rdE", 32'(rdE_out), 32'(r.rde));
                        check("retire rdIdx", 32'(rdIdx_out), 32'(r.ridx));
                        check("retire rdData", rdData_out, r.rdata);
`ifdef MEM_MISALIGN_CHECK_EN
                        check("retire misalign", 32'(misalign_out), 32'(r.misal));
`endif
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " memReq"},  32'(bus.memReq_out), 32'd0);
        check({tag, " mem_wr"},  32'(bus.mem_wr_out), 32'd0);
        check({tag, " mem_a"},   32'(bus.mem_a_out), 32'd0);
        check({tag, " mem_dout"},32'(bus.mem_dout_out), 32'd0);
        check({tag, " stall"},   32'(stall_out), 32'd0);
        check({tag, " rdE"},     32'(rdE_out), 32'd0);
        check({tag, " rdIdx"},   32'(rdIdx_out), 32'd0);
        check({tag, " rdData"},  rdData_out, 32'd0);
    endtask

    initial begin
        int cnt;
        logic [`instIdxRange] ops [10];
        logic [31:0] a;
        ops = '{`idLB, `idLBU, `idLH, `idLHU, `idLW, `idSB, `idSH, `idSW, `idADDI, `idNOP};

        // preload RAM and the reference memory identically
        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        ram[32'h200] = 8'h80; ram[32'h201] = 8'hFE; ram[32'h202] = 8'hFF;
        ref_mem = ram;

        // reset with a live-looking instruction on the inputs: outputs must still read 0
        rst_in          = 1'b1;
        bus.memGrant_in = 1'b1;
        instIdx_in      = `idLW;
        memAddr_in      = 32'h100;
        valStore_in     = 32'h0;
        rdE_in          = 1'b1;
        rdIdx_in        = 5'd7;
        rdData_in       = 32'hABCD;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        @(posedge clk_in);
        #1;
        drive_idle();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_reset stall", 32'(stall_out), 32'd0);
        check("post_reset memReq", 32'(bus.memReq_out), 32'd0);
        @(posedge clk_in);
        #1;

        // directed cases
        run_instr(`idLW,   32'h100, 32'h0,        1'b1, 5'd1, 32'h0, 0, 5, "LW_0x100");
        run_instr(`idLB,   32'h200, 32'h0,        1'b1, 5'd2, 32'h0, 0, 2, "LB_0x200");
        run_instr(`idLBU,  32'h200, 32'h0,        1'b1, 5'd2, 32'h0, 0, 2, "LBU_0x200");
        run_instr(`idLH,   32'h201, 32'h0,        1'b1, 5'd4, 32'h0, 0, -1, "LH_0x201");
        run_instr(`idSW,   32'h300, 32'hDEADBEEF, 1'b1, 5'd5, 32'h0, 0, 4, "SW_0x300");
        run_instr(`idLW,   32'h300, 32'h0,        1'b1, 5'd6, 32'h0, 2, 7, "LW_grant_drop");
        run_instr(`idSB,   32'h310, 32'h000000A5, 1'b0, 5'd0, 32'h0, 0, 1, "SB_0x310");
        run_instr(`idADDI, 32'h0,   32'h0,        1'b1, 5'd3, 32'd5, 0, 0, "ADDI_after_SB");
`ifdef MEM_MISALIGN_CHECK_EN
        run_instr(`idSW,   32'h302, 32'h11223344, 1'b0, 5'd0, 32'h0, 0, 0, "SW_misaligned");
`else
        run_instr(`idSW,   32'h302, 32'h11223344, 1'b0, 5'd0, 32'h0, 0, 4, "SW_misaligned");
`endif
        run_instr(`idSW,   32'hFFFFFFFE, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0, 0, -1, "SW_wrap");
        run_instr(`idLW,   32'hFFFFFFFE, 32'h0,        1'b1, 5'd9, 32'h0, 0, -1, "LW_wrap");

        // reset in the middle of a word load after two bytes have been issued
        bus_q.push_back('{wr: 1'b0, addr: 32'h100, data: 8'h00});
        bus_q.push_back('{wr: 1'b0, addr: 32'h101, data: 8'h00});
        instIdx_in      = `idLW;
        memAddr_in      = 32'h100;
        rdE_in          = 1'b1;
        rdIdx_in        = 5'd8;
        bus.memGrant_in = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            if (bus.memReq_out && bus.memGrant_in) cnt++;
            if (cnt == 2) break;
            @(posedge clk_in);
            #1;
        end
        check("midreset issued_bytes", 32'(cnt), 32'd2);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        drive_idle();
        @(negedge clk_in);
        check_all_zero("midreset during");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check_all_zero("midreset after");
        @(posedge clk_in);
        #1;
        run_instr(`idLW, 32'h100, 32'h0, 1'b1, 5'd1, 32'h0, 0, 5, "LW_after_reset");

        // randomized mix with random grant
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h400 + 32'($urandom_range(0, 15));
            run_instr(ops[$urandom_range(0, 9)], a, $urandom, 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1), -1, "random");
        end

        repeat (3) @(posedge clk_in);
        check("leftover bus expectations", 32'(bus_q.size()), 32'd0);
        check("leftover retire expectations", 32'(ret_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global bound on the run
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
